// File: rtl/io_pkg.sv
// Shared I/O definitions: default data width, word type and per-access status
// used by the FIFO controller and the core's I/O decode.
package io_pkg;

  localparam int IO_DATA_W = 64;

  typedef logic [IO_DATA_W-1:0] io_word_t;

  typedef enum logic [1:0] {
    IO_IDLE,
    IO_OK,
    IO_ERR
  } io_status_e;

  // Status of one requested access given whether its FIFO is blocking it.
  function automatic io_status_e access_status(input logic req, input logic blocked);
    if (!req) return IO_IDLE;
    return blocked ? IO_ERR : IO_OK;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port. Pointers carry an
// extra wrap bit so full/empty/count come straight from the registered pointers.
module io_sync_fifo
  import io_pkg::*;
#(
  parameter  int DATA_W = IO_DATA_W,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int CNT_W  = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              push_ok, pop_ok;

  // Flags come from the pointers at the start of the cycle, so a same-cycle
  // pop never makes room for a push on a full FIFO (and vice versa on empty).
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i  && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + CNT_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only meaningful
  // between the pointers, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/io_fifo_controller.sv
// Buffered core<->device I/O controller: TX and RX FIFOs plus the registered
// core-side read data and per-access ready/error strobes.
module io_fifo_controller
  import io_pkg::*;
#(
  parameter  int DATA_W = IO_DATA_W,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              io_write,
  input  logic              io_read,
  output logic [DATA_W-1:0] data_out,
  output logic              io_ready,
  output logic              io_err,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  rx_count,
  output logic [DATA_W-1:0] dev_out_data,
  output logic              dev_out_valid,
  input  logic              dev_out_ready,
  input  logic [DATA_W-1:0] dev_in_data,
  input  logic              dev_in_valid,
  output logic              dev_in_ready
);

  logic              tx_full, tx_empty;
  logic              rx_full, rx_empty;
  logic [DATA_W-1:0] rx_head;

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              io_ready_q, io_ready_d;
  logic              io_err_q,   io_err_d;
  io_status_e        wr_status, rd_status;

  io_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (io_write),
    .wdata_i (data_in),
    .pop_i   (dev_out_ready),
    .rdata_o (dev_out_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  io_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (dev_in_valid && dev_in_ready),
    .wdata_i (dev_in_data),
    .pop_i   (io_read),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  assign dev_out_valid = !tx_empty;
  assign dev_in_ready  = !rx_full && !reset;

  always_comb begin
    wr_status  = access_status(io_write, tx_full);
    rd_status  = access_status(io_read,  rx_empty);
    data_out_d = data_out_q;
    if (rd_status == IO_OK) data_out_d = rx_head;
    io_ready_d = (wr_status == IO_OK)  || (rd_status == IO_OK);
    io_err_d   = (wr_status == IO_ERR) || (rd_status == IO_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= '0;
      io_ready_q <= 1'b0;
      io_err_q   <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      io_ready_q <= io_ready_d;
      io_err_q   <= io_err_d;
    end
  end

  assign data_out = data_out_q;
  assign io_ready = io_ready_q;
  assign io_err   = io_err_q;

endmodule
